// File: rtl/acc_cpu_pkg.sv
// ---------------------------------------------------------------------------
// acc_cpu_pkg
// Shared definitions for the accumulator CPU microsequencer:
//   - instruction opcodes (IR[31:24])
//   - ALU operation encoding driven on alu_op
//   - sequencer state enumeration
//   - fault_code values
//   - helpers: opcode legality and opcode -> ALU op mapping
// ---------------------------------------------------------------------------
package acc_cpu_pkg;

    // Instruction opcodes
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_STORE  = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_AND    = 8'h05;
    localparam logic [7:0] OP_OR     = 8'h06;
    localparam logic [7:0] OP_NOT    = 8'h07;
    localparam logic [7:0] OP_SHR    = 8'h08;
    localparam logic [7:0] OP_SHL    = 8'h09;
    localparam logic [7:0] OP_JMP    = 8'h0A;
    localparam logic [7:0] OP_JMPGEZ = 8'h0B;
    localparam logic [7:0] OP_HALT   = 8'h0F;

    // ALU operation encoding
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_NOT  = 3'd4;
    localparam logic [2:0] ALU_SHR  = 3'd5;
    localparam logic [2:0] ALU_SHL  = 3'd6;
    localparam logic [2:0] ALU_PASS = 3'd7;

    // Fault codes
    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    // Memory wait counter width; timeouts are limited to 1..255 cycles
    localparam int TMR_W = 8;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_M,
        ST_DECODE_A,
        ST_DECODE,
        ST_OPER_A,
        ST_OPER_M,
        ST_STORE_B,
        ST_STORE_M,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_e;

    // Opcodes 0x00..0x0B are contiguous and all legal; HALT sits apart at 0x0F
    function automatic logic op_is_legal(input logic [7:0] op);
        return (op <= OP_JMPGEZ) || (op == OP_HALT);
    endfunction

    // LOAD passes memory data straight through the ALU into ACC
    function automatic logic [2:0] alu_for_op(input logic [7:0] op);
        logic [2:0] res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            OP_NOT:  res = ALU_NOT;
            OP_SHR:  res = ALU_SHR;
            OP_SHL:  res = ALU_SHL;
            default: res = ALU_PASS;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/acc_cpu_sequencer_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles a memory request has waited for mem_ready and flags the
// cycle in which the wait would reach MEM_TIMEOUT.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   hold the counter at zero (asserted outside request states)
//   enable   in   request state with mem_ready low this cycle
//   timeout  out  this not-ready cycle is the MEM_TIMEOUT-th one
// ---------------------------------------------------------------------------
module mem_wait_timer
    import acc_cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // count_q holds the number of earlier not-ready cycles, so the current
    // not-ready cycle is the MEM_TIMEOUT-th one when count_q is one short.
    // A ready cycle never enables the timer, which gives mem_ready priority.
    always_comb begin
        count_d = count_q;
        timeout = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TMR_W'(1);
            timeout = (count_q == TMR_W'(MEM_TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/acc_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// acc_cpu_sequencer
// Moore microsequencer for the accumulator CPU datapath. Runs the
// fetch / decode / execute loop and drives one load strobe per datapath
// register, the ALU op and memory read/write requests.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse leaving IDLE
//   ir_opcode[7:0]        IR[31:24], valid from the cycle after ir_ld
//   acc_neg               ACC sign flag
//   mem_ready             memory completes the current request this cycle
//   mar_ld_pc, mar_ld_ir  MAR load strobes
//   mbr_ld_mem, mbr_ld_acc MBR load strobes
//   ir_ld, pc_inc, pc_ld_ir, acc_ld_alu  register load strobes
//   alu_op[2:0]           ALU operation (PASS when idle)
//   mem_rd, mem_wr        memory requests, held until mem_ready
//   busy, halted, fault   status flags
//   fault_code[1:0]       0 none, 1 illegal opcode, 2 memory timeout
//   instr_count[CNT_W-1:0] legal non-HALT instructions decoded since reset
// ---------------------------------------------------------------------------
module acc_cpu_sequencer
    import acc_cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       ir_opcode,
    input  logic             acc_neg,
    input  logic             mem_ready,
    output logic             mar_ld_pc,
    output logic             mar_ld_ir,
    output logic             mbr_ld_mem,
    output logic             mbr_ld_acc,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld_ir,
    output logic             acc_ld_alu,
    output logic [2:0]       alu_op,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic in_req;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_timeout;

    // The three request states are never adjacent, so holding the timer
    // cleared outside them guarantees a fresh count on every entry.
    assign in_req     = (state_q == ST_FETCH_M) || (state_q == ST_OPER_M) ||
                        (state_q == ST_STORE_M);
    assign tmr_clear  = !in_req;
    assign tmr_enable = in_req && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .timeout (tmr_timeout)
    );

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT) &&
                         (state_q != ST_FAULT);
    assign halted      = (state_q == ST_HALT);
    assign fault       = (state_q == ST_FAULT);
    assign fault_code  = fault_code_q;
    assign instr_count = instr_count_q;

    // Next-state and strobe decode. Strobes come from the registered state,
    // so an asynchronous reset drops them immediately; only mbr_ld_mem
    // (mem_ready) and pc_ld_ir (opcode/flag) look at live inputs.
    always_comb begin
        state_d       = state_q;
        fault_code_d  = fault_code_q;
        instr_count_d = instr_count_q;
        mar_ld_pc     = 1'b0;
        mar_ld_ir     = 1'b0;
        mbr_ld_mem    = 1'b0;
        mbr_ld_acc    = 1'b0;
        ir_ld         = 1'b0;
        pc_inc        = 1'b0;
        pc_ld_ir      = 1'b0;
        acc_ld_alu    = 1'b0;
        alu_op        = ALU_PASS;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH_A;
            end
            ST_FETCH_A: begin
                mar_ld_pc = 1'b1;
                state_d   = ST_FETCH_M;
            end
            ST_FETCH_M: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    mbr_ld_mem = 1'b1;
                    state_d    = ST_DECODE_A;
                end else if (tmr_timeout) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE_A: begin
                ir_ld   = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (op_is_legal(ir_opcode) && (ir_opcode != OP_HALT)) begin
                    instr_count_d = instr_count_q + CNT_W'(1);
                end
                case (ir_opcode)
                    OP_NOP: state_d = ST_FETCH_A;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR:
                        state_d = ST_OPER_A;
                    OP_NOT, OP_SHR, OP_SHL:
                        state_d = ST_EXEC;
                    OP_JMP: begin
                        pc_ld_ir = 1'b1;
                        state_d  = ST_FETCH_A;
                    end
                    OP_JMPGEZ: begin
                        pc_ld_ir = !acc_neg;
                        state_d  = ST_FETCH_A;
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: begin
                        state_d      = ST_FAULT;
                        fault_code_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_OPER_A: begin
                mar_ld_ir = 1'b1;
                state_d   = (ir_opcode == OP_STORE) ? ST_STORE_B : ST_OPER_M;
            end
            ST_OPER_M: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    mbr_ld_mem = 1'b1;
                    state_d    = ST_EXEC;
                end else if (tmr_timeout) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_STORE_B: begin
                mbr_ld_acc = 1'b1;
                state_d    = ST_STORE_M;
            end
            ST_STORE_M: begin
                mem_wr = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH_A;
                end else if (tmr_timeout) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_EXEC: begin
                acc_ld_alu = 1'b1;
                alu_op     = alu_for_op(ir_opcode);
                state_d    = ST_FETCH_A;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, fault code and retired-instruction counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fault_code_q  <= FAULT_NONE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fault_code_q  <= fault_code_d;
            instr_count_q <= instr_count_d;
        end
    end

endmodule
